// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transmitter: parity modes,
// FSM state encodings and the data-bit parity helper.
package uart_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    // XOR of the low 'width' bits of v (even parity); bits above width are ignored
    function automatic logic xor_bits(input logic [8:0] v, input int unsigned width);
        logic [8:0] mask;
        mask = 9'((10'd1 << width) - 10'd1);
        return ^(v & mask);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with registered storage; pointers carry one extra wrap bit
// so full and empty are distinguished without a separate counter.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             do_push;
    logic             do_pop;

    assign count_o = wptr_q - rptr_q;
    assign full_o  = (count_o == CW'(DEPTH));
    assign empty_o = (wptr_q == rptr_q);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) wptr_d = wptr_q + CW'(1);
        if (do_pop)  rptr_d = rptr_q + CW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage needs no reset: entries are only read after being written
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: TX FIFO feeding a START/DATA/PARITY/STOP
// serialiser with registered line, active, done and overflow outputs.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 87,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          i_Clock,
    input  logic                          i_Reset,
    input  logic                          i_Tx_DV,
    input  logic [DATA_BITS-1:0]          i_Tx_Byte,
    output logic                          o_Tx_Ready,
    output logic                          o_Overflow,
    output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count,
    output logic                          o_Tx_Serial,
    output logic                          o_Tx_Active,
    output logic                          o_Tx_Done
);

    localparam int unsigned TW = $clog2(CLKS_PER_BIT);
    localparam int unsigned IW = $clog2(DATA_BITS);

    logic [2:0]           state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 serial_q, serial_d;
    logic                 active_q, active_d;
    logic                 done_q, done_d;
    logic                 ovf_q, ovf_d;

    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_pop;
    logic [DATA_BITS-1:0] fifo_rdata;
    logic                 bit_end;
    logic                 even_par;

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (i_Clock),
        .rst_i   (i_Reset),
        .push_i  (i_Tx_DV),
        .wdata_i (i_Tx_Byte),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (o_Fifo_Count)
    );

    assign o_Tx_Ready = !fifo_full;
    assign bit_end    = (timer_q == TW'(CLKS_PER_BIT - 1));
    assign even_par   = xor_bits(9'(fifo_rdata), DATA_BITS);

    // Next-state, datapath and registered-output logic
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        par_d    = par_q;
        serial_d = 1'b1;
        active_d = 1'b0;
        done_d   = 1'b0;
        ovf_d    = i_Tx_DV && fifo_full;
        fifo_pop = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rdata;
                    par_d    = (PARITY == PAR_ODD) ? ~even_par : even_par;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (idx_q == IW'(DATA_BITS - 1)) begin
                        idx_d   = '0;
                        state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        shift_d = shift_q >> 1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) state_d = ST_STOP;
            end
            ST_STOP: begin
                // idx_q reused to count stop bits; it is back at 0 when leaving
                if (bit_end) begin
                    if (idx_q == IW'(STOP_BITS - 1)) begin
                        idx_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if ((state_d != state_q) || bit_end || (state_q == ST_IDLE)) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + TW'(1);
        end

        // Line value is registered for the state being entered
        case (state_d)
            ST_START:  serial_d = 1'b0;
            ST_DATA:   serial_d = shift_d[0];
            ST_PARITY: serial_d = par_d;
            default:   serial_d = 1'b1;
        endcase

        active_d = (state_d != ST_IDLE);
        done_d   = (state_q == ST_STOP) && (state_d == ST_IDLE);
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q  <= ST_IDLE;
            timer_q  <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            serial_q <= 1'b1;
            active_q <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            serial_q <= serial_d;
            active_q <= active_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
        end
    end

    assign o_Tx_Serial = serial_q;
    assign o_Tx_Active = active_q;
    assign o_Tx_Done   = done_q;
    assign o_Overflow  = ovf_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: five configurations checked every cycle against a
// waveform-level model, plus hand-computed expectations for the directed cases.
module tb_uart_tx_param;

    localparam int NDUT  = 5;
    localparam int DEPTH = 4;
    localparam int CPB_A [NDUT] = '{4, 4, 4, 4, 3};
    localparam int DB_A  [NDUT] = '{8, 8, 8, 9, 5};
    localparam int PAR_A [NDUT] = '{0, 2, 1, 0, 1};
    localparam int SB_A  [NDUT] = '{1, 1, 1, 2, 2};

    logic       clk;
    logic       rst;
    logic       dv   [NDUT];
    logic [8:0] din  [NDUT];
    logic       rdy  [NDUT];
    logic       ovf  [NDUT];
    logic       ser  [NDUT];
    logic       act  [NDUT];
    logic       done [NDUT];
    logic [2:0] cnt  [NDUT];

    int n_checks;
    int n_err;
    int cyc;

    uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
        .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv[0]), .i_Tx_Byte(din[0][7:0]),
        .o_Tx_Ready(rdy[0]), .o_Overflow(ovf[0]), .o_Fifo_Count(cnt[0]),
        .o_Tx_Serial(ser[0]), .o_Tx_Active(act[0]), .o_Tx_Done(done[0]));
    uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
        .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv[1]), .i_Tx_Byte(din[1][7:0]),
        .o_Tx_Ready(rdy[1]), .o_Overflow(ovf[1]), .o_Fifo_Count(cnt[1]),
        .o_Tx_Serial(ser[1]), .o_Tx_Active(act[1]), .o_Tx_Done(done[1]));
    uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u2 (
        .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv[2]), .i_Tx_Byte(din[2][7:0]),
        .o_Tx_Ready(rdy[2]), .o_Overflow(ovf[2]), .o_Fifo_Count(cnt[2]),
        .o_Tx_Serial(ser[2]), .o_Tx_Active(act[2]), .o_Tx_Done(done[2]));
    uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(9), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u3 (
        .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv[3]), .i_Tx_Byte(din[3][8:0]),
        .o_Tx_Ready(rdy[3]), .o_Overflow(ovf[3]), .o_Fifo_Count(cnt[3]),
        .o_Tx_Serial(ser[3]), .o_Tx_Active(act[3]), .o_Tx_Done(done[3]));
    uart_tx_param #(.CLKS_PER_BIT(3), .DATA_BITS(5), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u4 (
        .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv[4]), .i_Tx_Byte(din[4][4:0]),
        .o_Tx_Ready(rdy[4]), .o_Overflow(ovf[4]), .o_Fifo_Count(cnt[4]),
        .o_Tx_Serial(ser[4]), .o_Tx_Active(act[4]), .o_Tx_Done(done[4]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int idx, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s dut%0d cyc=%0d got=%0d exp=%0d", name, idx, cyc, got, exp);
        end
    endtask

    // Reference model: queued words plus the line waveform of the frame in flight
    int         mq     [NDUT][DEPTH];
    int         mhead  [NDUT];
    int         msize  [NDUT];
    logic [15:0] mframe [NDUT];
    int         mlen   [NDUT];
    int         mpos   [NDUT];
    logic       e_ser  [NDUT];
    logic       e_act  [NDUT];
    logic       e_done [NDUT];
    logic       e_ovf  [NDUT];
    int         e_cnt  [NDUT];
    bit         model_ok;

    function automatic logic [15:0] frame_of(input int i, input int w);
        logic [15:0] f;
        int ones;
        f    = '1;
        f[0] = 1'b0;
        ones = 0;
        for (int j = 0; j < DB_A[i]; j++) begin
            f[1+j] = w[j];
            ones += int'(w[j]);
        end
        if (PAR_A[i] == 2) f[1+DB_A[i]] = ((ones % 2) == 1);
        if (PAR_A[i] == 1) f[1+DB_A[i]] = ((ones % 2) == 0);
        return f;
    endfunction

    task automatic model_step();
        for (int i = 0; i < NDUT; i++) begin
            if (rst) begin
                mhead[i] = 0; msize[i] = 0; mlen[i] = 0; mpos[i] = 0;
                e_ser[i] = 1'b1; e_act[i] = 1'b0; e_done[i] = 1'b0; e_ovf[i] = 1'b0; e_cnt[i] = 0;
            end else begin
                logic prev_act;
                bit   was_full;
                int   w;
                prev_act = e_act[i];
                was_full = (msize[i] == DEPTH);
                if (!prev_act && msize[i] > 0) begin
                    w         = mq[i][mhead[i]];
                    mhead[i]  = (mhead[i] + 1) % DEPTH;
                    msize[i]--;
                    mframe[i] = frame_of(i, w);
                    mlen[i]   = (1 + DB_A[i] + ((PAR_A[i] != 0) ? 1 : 0) + SB_A[i]) * CPB_A[i];
                    mpos[i]   = 0;
                end
                e_ovf[i] = 1'b0;
                if (dv[i]) begin
                    if (was_full) begin
                        e_ovf[i] = 1'b1;
                    end else begin
                        mq[i][(mhead[i] + msize[i]) % DEPTH] = int'(din[i]) & ((1 << DB_A[i]) - 1);
                        msize[i]++;
                    end
                end
                if (mpos[i] < mlen[i]) begin
                    e_ser[i] = mframe[i][mpos[i] / CPB_A[i]];
                    e_act[i] = 1'b1;
                    mpos[i]++;
                end else begin
                    e_ser[i] = 1'b1;
                    e_act[i] = 1'b0;
                end
                e_done[i] = prev_act && !e_act[i];
                e_cnt[i]  = msize[i];
            end
        end
        if (rst) model_ok = 1'b1;
    endtask

    initial begin
        cyc = 0;
        model_ok = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            model_step();
        end
    end

    // Every-cycle compare of all outputs against the model
    initial begin
        forever begin
            @(negedge clk);
            if (model_ok) begin
                for (int i = 0; i < NDUT; i++) begin
                    chk("serial",   i, int'(ser[i]),  int'(e_ser[i]));
                    chk("active",   i, int'(act[i]),  int'(e_act[i]));
                    chk("done",     i, int'(done[i]), int'(e_done[i]));
                    chk("overflow", i, int'(ovf[i]),  int'(e_ovf[i]));
                    chk("count",    i, int'(cnt[i]),  e_cnt[i]);
                    chk("ready",    i, int'(rdy[i]),  (e_cnt[i] < DEPTH) ? 1 : 0);
                end
            end
        end
    end

    task automatic idle_inputs();
        for (int i = 0; i < NDUT; i++) begin
            dv[i]  = 1'b0;
            din[i] = '0;
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int k;
        int rel;
        int act_n;
        int done_n;
        int ovf_n;
        logic [9:0] seq_a5;
        seq_a5 = 10'b1101001010;
        n_checks = 0;
        n_err    = 0;
        rst = 1'b1;
        idle_inputs();
        wait_cycles(3);
        chk("reset_serial", 0, int'(ser[0]), 1);
        chk("reset_active", 0, int'(act[0]), 0);
        chk("reset_count",  0, int'(cnt[0]), 0);
        chk("reset_ready",  0, int'(rdy[0]), 1);
        rst = 1'b0;
        wait_cycles(3);

        // 0xA5 on the 8-bit configs, 0x1FF on the 9-bit/2-stop config
        k = cyc;
        for (int i = 0; i < NDUT; i++) dv[i] = 1'b1;
        din[0] = 9'h0A5; din[1] = 9'h0A5; din[2] = 9'h0A5; din[3] = 9'h1FF; din[4] = 9'h013;
        wait_cycles(1);
        idle_inputs();
        act_n = 0; done_n = 0;
        repeat (60) begin
            rel = cyc - k;
            if (rel >= 2 && rel < 42 && ((rel - 2) % 4) == 1)
                chk("a5_8n1_bit", 0, int'(ser[0]), int'(seq_a5[(rel - 2) / 4]));
            if (rel == 2)  chk("a5_start_latency", 0, int'(ser[0]), 0);
            if (rel == 39) begin
                chk("a5_even_parity", 1, int'(ser[1]), 0);
                chk("a5_odd_parity",  2, int'(ser[2]), 1);
            end
            if (rel >= 2 && rel < 50) chk("1ff_line", 3, int'(ser[3]), (rel < 6) ? 0 : 1);
            if (rel == 42) chk("a5_done_cycle", 0, int'(done[0]), 1);
            if (rel == 46) chk("a5_par_done_cycle", 1, int'(done[1]), 1);
            if (rel == 50) chk("1ff_done_cycle", 3, int'(done[3]), 1);
            act_n  += int'(act[0]);
            done_n += int'(done[0]);
            wait_cycles(1);
        end
        chk("a5_active_cycles", 0, act_n, 40);
        chk("a5_done_pulses",   0, done_n, 1);
        wait_cycles(20);

        // 0x07 with even parity
        k = cyc;
        dv[1] = 1'b1; din[1] = 9'h007;
        wait_cycles(1);
        idle_inputs();
        repeat (50) begin
            rel = cyc - k;
            if (rel == 39) chk("07_even_parity", 1, int'(ser[1]), 1);
            wait_cycles(1);
        end

        // Back-to-back 0x11, 0x22, 0x33
        k = cyc;
        dv[0] = 1'b1; din[0] = 9'h011;
        wait_cycles(1);
        chk("b2b_count1", 0, int'(cnt[0]), 1);
        din[0] = 9'h022;
        wait_cycles(1);
        chk("b2b_count2", 0, int'(cnt[0]), 1);
        din[0] = 9'h033;
        wait_cycles(1);
        chk("b2b_count3", 0, int'(cnt[0]), 2);
        idle_inputs();
        done_n = 0;
        repeat (140) begin
            done_n += int'(done[0]);
            wait_cycles(1);
        end
        chk("b2b_done_pulses", 0, done_n, 3);
        chk("b2b_drained", 0, int'(cnt[0]), 0);

        // Six pushes into a four-deep FIFO
        k = cyc;
        ovf_n = 0;
        for (int r = 0; r < 6; r++) begin
            dv[0] = 1'b1; din[0] = 9'(8'h40 + r);
            if (r == 5) chk("ovf_ready_low", 0, int'(rdy[0]), 0);
            ovf_n += int'(ovf[0]);
            wait_cycles(1);
        end
        idle_inputs();
        chk("ovf_pulse_cycle", 0, int'(ovf[0]), 1);
        repeat (240) begin
            ovf_n += int'(ovf[0]);
            wait_cycles(1);
        end
        chk("ovf_pulse_count", 0, ovf_n, 1);

        // Reset during the data bits of 0x3C
        k = cyc;
        dv[0] = 1'b1; din[0] = 9'h03C;
        wait_cycles(1);
        idle_inputs();
        wait_cycles(9);
        rst = 1'b1;
        wait_cycles(1);
        rst = 1'b0;
        chk("rst_mid_serial", 0, int'(ser[0]), 1);
        chk("rst_mid_active", 0, int'(act[0]), 0);
        chk("rst_mid_count",  0, int'(cnt[0]), 0);
        done_n = 0;
        repeat (40) begin
            done_n += int'(done[0]);
            wait_cycles(1);
        end
        chk("rst_mid_no_done", 0, done_n, 0);
        dv[0] = 1'b1; din[0] = 9'h05A;
        wait_cycles(1);
        idle_inputs();
        wait_cycles(60);

        // Random traffic on all configurations
        repeat (3000) begin
            for (int i = 0; i < NDUT; i++) begin
                dv[i]  = (($urandom % 5) == 0);
                din[i] = 9'($urandom);
            end
            rst = (($urandom % 700) == 0);
            wait_cycles(1);
        end
        idle_inputs();
        rst = 1'b0;
        wait_cycles(300);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
